time_set_multi: RTL and testbench

Parametrised successor to the MM:SS time-set service. It edits a BCD time of two fields (MM:SS) or three fields (HH:MM:SS) digit by digit from four debounced push-button levels. It adds preset load on entry, auto-repeat on held up/down, an hour-range limit, and a blink mask for the selected digit. It sits between the button debouncers and the 7-segment display/countdown logic, and hands the finished value downstream with a one-cycle `finish` pulse.

---
 rtl/time_set_multi.sv | 194 +++++++++++++++++++
 tb/tb_time_set_multi.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_multi.sv
// time_set_multi: digit-by-digit BCD MM:SS / HH:MM:SS editor.
// Ports: clk, reset (sync, active-high), enable (edit mode), btn_u/d/l/r
// (debounced levels), preset (BCD loaded on entry), num (BCD value),
// sel (one-hot digit), blank (blink mask), finish (one-cycle end pulse).
module time_set_multi #(
  parameter int FIELDS       = 2,
  parameter int HOUR_MAX     = 23,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int BLINK_HALF   = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                btn_u,
  input  logic                btn_d,
  input  logic                btn_l,
  input  logic                btn_r,
  input  logic [8*FIELDS-1:0] preset,
  output logic [8*FIELDS-1:0] num,
  output logic [2*FIELDS-1:0] sel,
  output logic [2*FIELDS-1:0] blank,
  output logic                finish
);

  localparam int D = 2 * FIELDS;
  localparam int W = 4 * D;
  localparam logic [3:0] HT = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HU = 4'(HOUR_MAX % 10);
  localparam logic [31:0] RD = 32'(REPEAT_DELAY);
  localparam logic [31:0] RR = 32'(REPEAT_RATE);
  localparam logic [31:0] BH = 32'(BLINK_HALF);

  typedef enum logic [1:0] {IDLE, EDIT, FINISH} state_t;

  state_t state, state_n;

  logic [W-1:0]  num_n, pre_ok;
  logic [D-1:0]  sel_n, blank_n, sel_l, sel_r;
  logic          fin_n;
  logic [3:0]    btn, btn_q, prs;
  logic          rep_act, rep_act_n;
  logic          rep_on, rep_on_n;
  logic [31:0]   rep_cnt, rep_cnt_n;
  logic [31:0]   blk_cnt, blk_cnt_n;
  logic          phase, phase_n;
  logic          ud_hold, ud_prs, rep_fire;
  logic          step_u, step_d, mv_l, mv_r, evt;
  logic [3:0]    pre_ht, v, mx;

  // Largest legal value of digit k; hour units depend on hour tens.
  function automatic logic [3:0] dmax(input int k, input logic [3:0] tens);
    if (FIELDS == 3 && k == D - 1) return HT;
    if (FIELDS == 3 && k == D - 2) return (tens == HT) ? HU : 4'd9;
    if (k % 2 == 1) return 4'd5;
    return 4'd9;
  endfunction

  assign btn = {btn_u, btn_d, btn_l, btn_r};
  assign prs = btn & ~btn_q;

  assign ud_hold = btn_u ^ btn_d;
  assign ud_prs  = ud_hold & (btn_u ? prs[3] : prs[2]);
  // Repeat only continues a hold that began with a press in edit mode.
  assign rep_fire = ud_hold & ~ud_prs & rep_act &
                    (rep_on ? (rep_cnt == RR) : (rep_cnt == RD));
  assign step_u = btn_u & ~btn_d & (ud_prs | rep_fire);
  assign step_d = btn_d & ~btn_u & (ud_prs | rep_fire);
  assign mv_l   = prs[1] & ~prs[0];
  assign mv_r   = prs[0] & ~prs[1];
  assign evt    = (|prs) | rep_fire;

  assign sel_l = {sel[D-2:0], sel[D-1]};
  assign sel_r = {sel[0], sel[D-1:1]};

  // Preset sanitised MSD first so hour units see the legal hour tens.
  always_comb begin
    pre_ok = '0;
    pre_ht = (preset[4*(D-1) +: 4] > HT) ? 4'd0 : preset[4*(D-1) +: 4];
    for (int k = 0; k < D; k++) begin
      if (preset[4*k +: 4] <= dmax(k, pre_ht))
        pre_ok[4*k +: 4] = preset[4*k +: 4];
    end
  end

  always_comb begin
    state_n   = state;
    num_n     = num;
    sel_n     = sel;
    fin_n     = 1'b0;
    rep_act_n = 1'b0;
    rep_on_n  = 1'b0;
    rep_cnt_n = '0;
    blk_cnt_n = '0;
    phase_n   = 1'b0;
    v         = '0;
    mx        = '0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n      = EDIT;
          num_n        = pre_ok;
          sel_n        = '0;
          sel_n[D-1]   = 1'b1;
        end
      end
      EDIT: begin
        if (!enable) begin
          state_n = FINISH;
          sel_n   = '0;
        end else begin
          if (ud_hold) begin
            if (ud_prs) begin
              rep_act_n = 1'b1;
              rep_cnt_n = 32'd1;
            end else if (rep_fire) begin
              rep_act_n = 1'b1;
              rep_on_n  = 1'b1;
              rep_cnt_n = 32'd1;
            end else if (rep_act) begin
              rep_act_n = 1'b1;
              rep_on_n  = rep_on;
              rep_cnt_n = rep_cnt + 32'd1;
            end
          end
          for (int k = 0; k < D; k++) begin
            if (sel[k]) begin
              v  = num[4*k +: 4];
              mx = dmax(k, num[4*(D-1) +: 4]);
              if (step_u)
                v = (v == mx) ? 4'd0 : v + 4'd1;
              else if (step_d)
                v = (v == 4'd0) ? mx : v - 4'd1;
              num_n[4*k +: 4] = v;
            end
          end
          // Hour tens reaching its max may push the hour past HOUR_MAX.
          if (FIELDS == 3 && sel[D-1] && (step_u | step_d) &&
              num_n[4*(D-1) +: 4] == HT && num[4*(D-2) +: 4] > HU)
            num_n[4*(D-2) +: 4] = HU;
          if (mv_l)
            sel_n = sel_l;
          else if (mv_r)
            sel_n = sel_r;
          if (evt) begin
            blk_cnt_n = '0;
            phase_n   = 1'b0;
          end else if (blk_cnt == BH - 32'd1) begin
            blk_cnt_n = '0;
            phase_n   = ~phase;
          end else begin
            blk_cnt_n = blk_cnt + 32'd1;
            phase_n   = phase;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
        fin_n   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    blank_n = (state_n == EDIT && phase_n) ? sel_n : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      num     <= '0;
      sel     <= '0;
      blank   <= '0;
      finish  <= 1'b0;
      btn_q   <= '0;
      rep_act <= 1'b0;
      rep_on  <= 1'b0;
      rep_cnt <= '0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      state   <= state_n;
      num     <= num_n;
      sel     <= sel_n;
      blank   <= blank_n;
      finish  <= fin_n;
      btn_q   <= btn;
      rep_act <= rep_act_n;
      rep_on  <= rep_on_n;
      rep_cnt <= rep_cnt_n;
      blk_cnt <= blk_cnt_n;
      phase   <= phase_n;
    end
  end

endmodule

// File: tb/tb_time_set_multi.sv
// tb_time_set_multi: directed + random check of time_set_multi.
// Two instances (MM:SS and HH:MM:SS) share stimulus, each has its own model.
module tb_time_set_multi;

  localparam int RD = 4;
  localparam int RR = 2;
  localparam int BH = 3;
  localparam int HM = 23;

  logic        clk = 1'b0;
  logic        reset, enable, bu, bd, bl, br;
  logic [23:0] preset;
  logic [15:0] num2;
  logic [3:0]  sel2, blank2;
  logic        fin2;
  logic [23:0] num3;
  logic [5:0]  sel3, blank3;
  logic        fin3;

  always #5 clk = ~clk;

  time_set_multi #(
    .FIELDS(2), .HOUR_MAX(HM), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .BLINK_HALF(BH)
  ) u2 (
    .clk(clk), .reset(reset), .enable(enable),
    .btn_u(bu), .btn_d(bd), .btn_l(bl), .btn_r(br),
    .preset(preset[15:0]), .num(num2), .sel(sel2),
    .blank(blank2), .finish(fin2)
  );

  time_set_multi #(
    .FIELDS(3), .HOUR_MAX(HM), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .BLINK_HALF(BH)
  ) u3 (
    .clk(clk), .reset(reset), .enable(enable),
    .btn_u(bu), .btn_d(bd), .btn_l(bl), .btn_r(br),
    .preset(preset), .num(num3), .sel(sel3),
    .blank(blank3), .finish(fin3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: digits as integers, selection as an index,
  // hold and blink as elapsed-cycle counts.
  int md[2][6];
  int mpos[2];
  int mmode[2];   // 0 idle, 1 edit, 2 finish
  int mheld[2];   // cycles since U/D press, -1 if no live hold
  int mblink[2];  // cycles since entry or last event
  bit mfin[2];
  bit mq[4];

  function automatic int nf(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int mmax(input int i, input int k);
    if (nf(i) == 3 && k == 5) return HM / 10;
    if (nf(i) == 3 && k == 4) return (md[i][5] == HM / 10) ? HM % 10 : 9;
    return (k % 2 == 1) ? 5 : 9;
  endfunction

  function automatic logic [31:0] exp_num(input int i);
    logic [31:0] x = 0;
    for (int k = 0; k < 2 * nf(i); k++)
      x = x | (32'(md[i][k]) << (4 * k));
    return x;
  endfunction

  function automatic logic [31:0] exp_sel(input int i);
    return (mpos[i] >= 0) ? (32'd1 << mpos[i]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_blank(input int i);
    if (mmode[i] == 1 && ((mblink[i] / BH) % 2) == 1) return exp_sel(i);
    return 32'd0;
  endfunction

  task automatic model_step();
    bit u, d, l, r, pu, pd, pl, pr;
    int nd, dir, v, mx, p;
    u = bu; d = bd; l = bl; r = br;
    pu = u && !mq[0]; pd = d && !mq[1];
    pl = l && !mq[2]; pr = r && !mq[3];
    for (int i = 0; i < 2; i++) begin
      nd = 2 * nf(i);
      mfin[i] = 1'b0;
      if (reset) begin
        for (int k = 0; k < 6; k++) md[i][k] = 0;
        mpos[i] = -1; mmode[i] = 0; mheld[i] = -1; mblink[i] = 0;
      end else begin
        case (mmode[i])
          0: begin
            if (enable) begin
              for (int k = nd - 1; k >= 0; k--) begin
                v = int'((preset >> (4 * k)) & 24'hF);
                md[i][k] = (v <= mmax(i, k)) ? v : 0;
              end
              mmode[i] = 1; mpos[i] = nd - 1;
              mheld[i] = -1; mblink[i] = 0;
            end
          end
          1: begin
            if (!enable) begin
              mmode[i] = 2; mpos[i] = -1; mheld[i] = -1;
            end else begin
              dir = 0;
              if (u == d) mheld[i] = -1;
              else if ((u && pu) || (d && pd)) begin
                mheld[i] = 0; dir = u ? 1 : -1;
              end else if (mheld[i] >= 0) begin
                mheld[i]++;
                if (mheld[i] == RD ||
                    (mheld[i] > RD && (mheld[i] - RD) % RR == 0))
                  dir = u ? 1 : -1;
              end
              if (dir != 0) begin
                p = mpos[i]; mx = mmax(i, p); v = md[i][p];
                if (dir > 0) v = (v == mx) ? 0 : v + 1;
                else v = (v == 0) ? mx : v - 1;
                md[i][p] = v;
                if (nf(i) == 3 && p == 5 && md[i][5] * 10 + md[i][4] > HM)
                  md[i][4] = HM % 10;
              end
              if (pl && !pr) mpos[i] = (mpos[i] + 1) % nd;
              else if (pr && !pl) mpos[i] = (mpos[i] + nd - 1) % nd;
              if (pu || pd || pl || pr || dir != 0) mblink[i] = 0;
              else mblink[i]++;
            end
          end
          default: begin
            mfin[i] = 1'b1; mmode[i] = 0;
          end
        endcase
      end
    end
    if (reset) begin
      mq[0] = 0; mq[1] = 0; mq[2] = 0; mq[3] = 0;
    end else begin
      mq[0] = u; mq[1] = d; mq[2] = l; mq[3] = r;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("num2", 32'(num2), exp_num(0));
    check("sel2", 32'(sel2), exp_sel(0));
    check("blank2", 32'(blank2), exp_blank(0));
    check("fin2", 32'(fin2), 32'(mfin[0]));
    check("num3", 32'(num3), exp_num(1));
    check("sel3", 32'(sel3), exp_sel(1));
    check("blank3", 32'(blank3), exp_blank(1));
    check("fin3", 32'(fin3), 32'(mfin[1]));
  endtask

  initial begin
    reset = 1; enable = 0; bu = 0; bd = 0; bl = 0; br = 0; preset = '0;
    tick(); tick();
    check("rst_num", 32'(num2), 32'h0);
    reset = 0;

    // reset in the middle of edit mode
    preset = 24'h001234; enable = 1; tick();
    check("load_1234", 32'(num2), 32'h1234);
    tick();
    reset = 1; tick();
    check("rst_mid_num", 32'(num2), 32'h0);
    check("rst_mid_sel", 32'(sel2), 32'h0);
    reset = 0; enable = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rst_no_fin", 32'(fin2), 32'h0);
    end

    // MM:SS editing
    preset = 24'h005909; enable = 1; tick();
    check("entry_sel", 32'(sel2), 32'h8);
    bd = 1; tick(); bd = 0; tick();
    check("d_digit3", 32'(num2), 32'h4909);
    bl = 1; tick();
    check("l_wrap", 32'(sel2), 32'h1);
    bl = 0; tick();
    bu = 1; tick(); bu = 0; tick();
    check("u_wrap", 32'(num2), 32'h4900);

    // leaving edit mode
    enable = 0; tick();
    check("exit_sel", 32'(sel2), 32'h0);
    check("exit_blank", 32'(blank2), 32'h0);
    tick();
    check("fin_pulse", 32'(fin2), 32'h1);
    tick();
    check("fin_end", 32'(fin2), 32'h0);

    // HH:MM:SS hour clamp and hour-units wrap
    preset = 24'h190000; enable = 1; tick();
    check("h_entry_sel", 32'(sel3), 32'h20);
    bu = 1; tick(); bu = 0; tick();
    check("h_clamp", 32'(num3), 32'h230000);
    br = 1; tick(); br = 0; tick();
    check("h_r_sel", 32'(sel3), 32'h10);
    bu = 1; tick(); bu = 0; tick();
    check("h_units_wrap", 32'(num3), 32'h200000);

    // auto-repeat on seconds units
    enable = 0; tick(); tick(); tick();
    preset = '0; enable = 1; tick();
    bl = 1; tick(); bl = 0; tick();
    bu = 1; tick();
    for (int n = 0; n < 8; n++) tick();
    check("rep_hold2", 32'(num2), 32'h4);
    check("rep_hold3", 32'(num3), 32'h4);
    bu = 0; tick();
    for (int n = 0; n < 5; n++) tick();
    check("rep_stop", 32'(num2), 32'h4);

    // simultaneous buttons
    bu = 1; bd = 1; tick(); bu = 0; bd = 0; tick();
    check("ud_both_num", 32'(num2), 32'h4);
    bl = 1; br = 1; tick(); bl = 0; br = 0; tick();
    check("lr_both_sel", 32'(sel2), 32'h1);
    bu = 1; bl = 1; tick();
    check("ul_num", 32'(num2), 32'h5);
    check("ul_sel", 32'(sel2), 32'h2);
    check("ul_blank", 32'(blank2), 32'h0);

    // blink cadence, then a press forces the digit visible
    bu = 0; bl = 0; tick(); tick(); tick();
    check("blink_on", 32'(blank2), 32'h2);
    tick(); tick();
    check("blink_on2", 32'(blank2), 32'h2);
    tick();
    check("blink_off", 32'(blank2), 32'h0);
    tick(); tick(); tick();
    check("blink_on3", 32'(blank2), 32'h2);
    br = 1; tick();
    check("press_blank", 32'(blank2), 32'h0);
    br = 0; tick();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(299) == 0);
      if ($urandom_range(59) == 0) enable = ~enable;
      if ($urandom_range(4) == 0) bu = ~bu;
      if ($urandom_range(4) == 0) bd = ~bd;
      if ($urandom_range(4) == 0) bl = ~bl;
      if ($urandom_range(4) == 0) br = ~br;
      preset = 24'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
